// File: rtl/ccc_ctrl_pkg.sv
// State encoding shared by the CCC/PLL controller and anything that decodes STATE.
package ccc_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_PWRDN     = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_STABLE    = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_e;

endpackage

// File: rtl/ccc_clken_accum.sv
// One clock-enable channel: a phase accumulator whose carry-out becomes a
// one-cycle strobe. Rate is inc_i / 2^ACC_W while en_i is held high.
module ccc_clken_accum #(
    parameter int ACC_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             strobe_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             strobe_q, strobe_d;
    logic [ACC_W:0]   sum;

    // Accumulate while enabled; a disabled channel restarts from phase zero.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, inc_i};
        acc_d    = '0;
        strobe_d = 1'b0;
        if (en_i) begin
            acc_d    = sum[ACC_W-1:0];
            strobe_d = sum[ACC_W];
        end
    end

    // Phase and strobe registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: rtl/ccc_pll_ctrl_clken.sv
// Fabric-side CCC/PLL bring-up controller: power-down sequencing, LOCK
// synchronisation and qualification, timeout retries, lock-loss recovery and
// status, plus per-channel fractional clock-enable strobes once qualified.
// Clocked from a free-running fabric clock, never from the PLL output.
module ccc_pll_ctrl_clken
    import ccc_ctrl_pkg::*;
#(
    parameter int NUM_CH           = 4,
    parameter int ACC_W            = 24,
    parameter int PD_CYC           = 64,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 3,
    parameter int AUTO_RECOVER     = 1,
    parameter int CNT_W            = 16
) (
    input  logic                             CLK,
    input  logic                             RESET_N,
    input  logic                             ENABLE,
    input  logic                             PLL_LOCK_0,
    output logic                             PLL_POWERDOWN_N_0,
    output logic                             READY,
    output logic                             FAULT,
    output logic [STATE_W-1:0]               STATE,
    output logic [$clog2(MAX_RETRY+1)-1:0]   RETRY_CNT,
    output logic [CNT_W-1:0]                 LOCK_LOSS_CNT,
    input  logic                             CLR_STATS,
    input  logic [NUM_CH-1:0]                CH_EN,
    input  logic [NUM_CH*ACC_W-1:0]          INC,
    output logic [NUM_CH-1:0]                CLKEN_OUT
);

    localparam int PD_W  = $clog2(PD_CYC + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYC + 1);
    localparam int RT_W  = $clog2(MAX_RETRY + 1);

    localparam logic [PD_W-1:0]  PD_LAST  = PD_W'(PD_CYC - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic               lock_m_q, lock_s_q;
    logic [PD_W-1:0]    pd_cnt_q, pd_cnt_d;
    logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [RT_W-1:0]    retry_q, retry_d;
    logic [CNT_W-1:0]   llc_q, llc_d;

    // Next state and counters. Timers default to zero so each one restarts on
    // entry to the state that uses it; the lock timeout spans WAIT_LOCK and
    // STABLE together so a flapping lock cannot stall a bring-up attempt.
    always_comb begin
        state_d   = state_q;
        pd_cnt_d  = '0;
        stb_cnt_d = '0;
        to_cnt_d  = '0;
        retry_d   = retry_q;
        llc_d     = llc_q;

        case (state_q)
            ST_OFF: begin
                retry_d = '0;
                if (ENABLE) state_d = ST_PWRDN;
            end
            ST_PWRDN: begin
                if (pd_cnt_q == PD_LAST) state_d = ST_WAIT_LOCK;
                else                     pd_cnt_d = pd_cnt_q + PD_W'(1);
            end
            ST_WAIT_LOCK, ST_STABLE: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (to_cnt_q >= TO_LAST) begin
                    // Timeout wins over any lock activity in the same cycle.
                    to_cnt_d = '0;
                    if (retry_q < RT_MAX) begin
                        retry_d = retry_q + RT_W'(1);
                        state_d = ST_PWRDN;
                    end else begin
                        state_d = ST_FAULT;
                    end
                end else if (state_q == ST_WAIT_LOCK) begin
                    if (lock_s_q) state_d = ST_STABLE;
                end else if (!lock_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (stb_cnt_q == STB_LAST) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                end else begin
                    stb_cnt_d = stb_cnt_q + STB_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s_q) begin
                    if (llc_q != '1) llc_d = llc_q + CNT_W'(1);
                    state_d = (AUTO_RECOVER != 0) ? ST_PWRDN : ST_FAULT;
                end
            end
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_OFF;
        endcase

        // Dropping ENABLE overrides everything, and a lock loss seen in the
        // same cycle is not counted.
        if (!ENABLE) begin
            state_d = ST_OFF;
            retry_d = '0;
            llc_d   = llc_q;
        end
        if (CLR_STATS) llc_d = '0;
    end

    // State, counters and the two-flop LOCK synchroniser.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q   <= ST_OFF;
            lock_m_q  <= 1'b0;
            lock_s_q  <= 1'b0;
            pd_cnt_q  <= '0;
            stb_cnt_q <= '0;
            to_cnt_q  <= '0;
            retry_q   <= '0;
            llc_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_m_q  <= PLL_LOCK_0;
            lock_s_q  <= lock_m_q;
            pd_cnt_q  <= pd_cnt_d;
            stb_cnt_q <= stb_cnt_d;
            to_cnt_q  <= to_cnt_d;
            retry_q   <= retry_d;
            llc_q     <= llc_d;
        end
    end

    assign PLL_POWERDOWN_N_0 = (state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE) ||
                               (state_q == ST_RUN);
    assign READY             = (state_q == ST_RUN);
    assign FAULT             = (state_q == ST_FAULT);
    assign STATE             = state_q;
    assign RETRY_CNT         = retry_q;
    assign LOCK_LOSS_CNT     = llc_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ccc_clken_accum #(
            .ACC_W(ACC_W)
        ) u_acc (
            .clk_i   (CLK),
            .rst_ni  (RESET_N),
            .en_i    (READY & CH_EN[i]),
            .inc_i   (INC[i*ACC_W +: ACC_W]),
            .strobe_o(CLKEN_OUT[i])
        );
    end

endmodule
